// File: rtl/kvadd2_pkg.sv
// Shared types and helpers for the two-vector add stream core.
// Holds the operating-mode and FSM-state enums plus small elaboration/decode helpers.
// No logic of its own; imported by every kvadd2 RTL file.
package kvadd2_pkg;

    typedef enum logic [1:0] {
        MODE_ADD  = 2'd0,
        MODE_SUB  = 2'd1,
        MODE_ADDC = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Number of independent lanes in one stream beat.
    function automatic int unsigned lane_count(input int unsigned dw, input int unsigned ew);
        return dw / ew;
    endfunction

    // Raw control code to mode; the reserved code 3 behaves as a plain add.
    function automatic mode_e decode_mode(input logic [1:0] raw);
        case (raw)
            2'd1:    return MODE_SUB;
            2'd2:    return MODE_ADDC;
            default: return MODE_ADD;
        endcase
    endfunction

    // Byte-enable bit idx of the final beat; a zero residual means a full beat.
    function automatic logic keep_bit(input int unsigned idx, input int unsigned nbytes,
                                      input int unsigned resid);
        if (resid == 0) begin
            return idx < nbytes;
        end
        return idx < resid;
    endfunction

endpackage

// File: rtl/kvadd2_skid_buffer.sv
// Two-entry output skid buffer carrying {tdata, tkeep, tlast} as one opaque word.
// Latency: a word pushed at cycle N is presented on pop at N+1; 1 word/cycle sustained.
// Backpressure: push_rdy drops only while the spare entry is occupied; pop_dat holds while stalled.
module kvadd2_skid_buffer #(
    parameter int unsigned W = 8
) (
    input  logic         aclk,
    input  logic         areset_n,
    input  logic         push_vld,
    output logic         push_rdy,
    input  logic [W-1:0] push_dat,
    output logic         pop_vld,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat
);

    logic [W-1:0] main_dat;
    logic [W-1:0] skid_dat;
    logic         main_vld;
    logic         skid_vld;

    // Ready comes straight from a flop so the upstream join never sees a combinational path from pop_rdy.
    assign push_rdy = !skid_vld;
    assign pop_vld  = main_vld;
    assign pop_dat  = main_dat;

    // Main register refills from the spare entry first; new words park in the spare only while stalled.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            main_dat <= '0;
            skid_dat <= '0;
        end else if (pop_rdy || !main_vld) begin
            if (skid_vld) begin
                main_dat <= skid_dat;
                main_vld <= 1'b1;
                skid_vld <= 1'b0;
            end else begin
                main_vld <= push_vld;
                if (push_vld) begin
                    main_dat <= push_dat;
                end
            end
        end else if (push_vld && push_rdy) begin
            skid_dat <= push_dat;
            skid_vld <= 1'b1;
        end
    end

endmodule

// File: rtl/kvadd2_vadd2_core.sv
// Stream core of the two-vector add kernel: joins A and B beat-wise into C = A+B / A-B / A+const.
// Latency: join handshake at cycle N gives m_axis_tvalid at N+1; full rate under continuous tready.
// Backpressure: A/B tready asserted only when both inputs (A only in ADDC) are valid and the output skid has room.
// Optional feature: define KVADD2_SATURATE_EN for signed saturating lanes instead of wrap-around.
module kvadd2_vadd2_core
    import kvadd2_pkg::*;
#(
    parameter int unsigned C_DATA_WIDTH      = 512,
    parameter int unsigned C_ELEM_WIDTH      = 32,
    parameter int unsigned C_XFER_SIZE_WIDTH = 32
) (
    input  logic                           aclk,
    input  logic                           areset_n,
    input  logic                           ap_start,
    output logic                           ap_done,
    output logic                           ap_idle,
    input  logic [C_XFER_SIZE_WIDTH-1:0]   ctrl_xfer_size_in_bytes,
    input  logic [1:0]                     ctrl_mode,
    input  logic [C_ELEM_WIDTH-1:0]        ctrl_constant,
    input  logic                           s_axis_a_tvalid,
    output logic                           s_axis_a_tready,
    input  logic [C_DATA_WIDTH-1:0]        s_axis_a_tdata,
    input  logic                           s_axis_a_tlast,
    input  logic                           s_axis_b_tvalid,
    output logic                           s_axis_b_tready,
    input  logic [C_DATA_WIDTH-1:0]        s_axis_b_tdata,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic [C_DATA_WIDTH-1:0]        m_axis_tdata,
    output logic [C_DATA_WIDTH/8-1:0]      m_axis_tkeep,
    output logic                           m_axis_tlast,
    output logic                           stat_err_tlast
);

    localparam int unsigned EW     = C_ELEM_WIDTH;
    localparam int unsigned XSW    = C_XFER_SIZE_WIDTH;
    localparam int unsigned NB     = C_DATA_WIDTH / 8;
    localparam int unsigned NB_LOG = $clog2(NB);
    localparam int unsigned LANES  = lane_count(C_DATA_WIDTH, C_ELEM_WIDTH);
    localparam int unsigned SB_W   = C_DATA_WIDTH + NB + 1;

    localparam logic [XSW:0]   NB_M1    = (C_XFER_SIZE_WIDTH+1)'(NB - 1);
    localparam logic [XSW-1:0] ONE_BEAT = (C_XFER_SIZE_WIDTH)'(1);

    state_e            state;
    mode_e             mode;
    logic [EW-1:0]     cst;
    logic [XSW-1:0]    beats_left;
    logic [NB-1:0]     keep_last;
    logic [NB-1:0]     keep_calc;
    logic [XSW:0]      beats_calc;
    logic [31:0]       resid;
    logic              addc;
    logic              is_last;
    logic              join_fire;
    logic              sb_push_rdy;
    logic [C_DATA_WIDTH-1:0] sum_dat;
    logic [SB_W-1:0]   sb_push_dat;
    logic [SB_W-1:0]   sb_pop_dat;

    // One lane: operands sign-extended by one bit so signed overflow is visible for the clamp.
    function automatic logic [EW-1:0] lane_op(input logic [EW-1:0] a, input logic [EW-1:0] b,
                                              input logic sub);
`ifdef KVADD2_SATURATE_EN
        logic [EW:0] wide;
        wide = sub ? ({a[EW-1], a} - {b[EW-1], b}) : ({a[EW-1], a} + {b[EW-1], b});
        if (wide[EW] != wide[EW-1]) begin
            return wide[EW] ? {1'b1, {(EW-1){1'b0}}} : {1'b0, {(EW-1){1'b1}}};
        end
        return wide[EW-1:0];
`else
        return sub ? (a - b) : (a + b);
`endif
    endfunction

    // Beat count rounds the byte count up to whole beats; the sum is one bit wider to avoid overflow.
    assign beats_calc = ({1'b0, ctrl_xfer_size_in_bytes} + NB_M1) >> NB_LOG;
    assign resid      = 32'(ctrl_xfer_size_in_bytes[NB_LOG-1:0]);

    assign addc      = (mode == MODE_ADDC);
    assign is_last   = (beats_left == ONE_BEAT);
    assign join_fire = (state == ST_RUN) && s_axis_a_tvalid && (addc || s_axis_b_tvalid) && sb_push_rdy;

    assign s_axis_a_tready = join_fire;
    assign s_axis_b_tready = join_fire && !addc;

    // Final-beat byte enables, computed from the control input and captured at start.
    always_comb begin
        keep_calc = '0;
        for (int unsigned k = 0; k < NB; k++) begin
            keep_calc[k] = keep_bit(k, NB, resid);
        end
    end

    // Lane-wise arithmetic on the live input beat; lanes never carry into each other.
    always_comb begin
        sum_dat = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            sum_dat[i*EW +: EW] = lane_op(s_axis_a_tdata[i*EW +: EW],
                                          addc ? cst : s_axis_b_tdata[i*EW +: EW],
                                          mode == MODE_SUB);
        end
    end

    assign sb_push_dat = {sum_dat, (is_last ? keep_last : {NB{1'b1}}), is_last};

    kvadd2_skid_buffer #(
        .W (SB_W)
    ) u_out_skid (
        .aclk     (aclk),
        .areset_n (areset_n),
        .push_vld (join_fire),
        .push_rdy (sb_push_rdy),
        .push_dat (sb_push_dat),
        .pop_vld  (m_axis_tvalid),
        .pop_rdy  (m_axis_tready),
        .pop_dat  (sb_pop_dat)
    );

    assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast} = sb_pop_dat;

    // Control FSM with registered ap_done/ap_idle/error flag and the per-run latched configuration.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state      <= ST_IDLE;
            mode       <= MODE_ADD;
            cst        <= '0;
            beats_left <= '0;
            keep_last  <= '1;
            ap_done    <= 1'b0;
            ap_idle    <= 1'b1;
            stat_err_tlast <= 1'b0;
        end else begin
            ap_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ap_start) begin
                        mode           <= decode_mode(ctrl_mode);
                        cst            <= ctrl_constant;
                        beats_left     <= beats_calc[XSW-1:0];
                        keep_last      <= keep_calc;
                        stat_err_tlast <= 1'b0;
                        ap_idle        <= 1'b0;
                        if (beats_calc == '0) begin
                            state   <= ST_DONE;
                            ap_done <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (join_fire) begin
                        beats_left <= beats_left - ONE_BEAT;
                        if (s_axis_a_tlast != is_last) begin
                            stat_err_tlast <= 1'b1;
                        end
                        if (is_last) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                        state   <= ST_DONE;
                        ap_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    ap_idle <= 1'b1;
                end
                default: begin
                    state   <= ST_IDLE;
                    ap_idle <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kvadd2_vadd2_core.sv
// Self-checking bench for kvadd2_vadd2_core (DW=512, EW=32): scenario tasks with a per-element reference model.
// Stimulus is randomised in data, valid and ready timing; expected beats are computed from element arithmetic.
// Builds with or without KVADD2_SATURATE_EN; the lane model follows the same macro.
module tb_kvadd2_vadd2_core;

    localparam int DW    = 512;
    localparam int EW    = 32;
    localparam int XSW   = 32;
    localparam int NB    = DW / 8;
    localparam int LANES = DW / EW;

    logic            aclk = 1'b0;
    logic            areset_n = 1'b1;
    logic            ap_start = 1'b0;
    logic            ap_done;
    logic            ap_idle;
    logic [XSW-1:0]  ctrl_xfer_size_in_bytes = '0;
    logic [1:0]      ctrl_mode = '0;
    logic [EW-1:0]   ctrl_constant = '0;
    logic            s_axis_a_tvalid = 1'b0;
    logic            s_axis_a_tready;
    logic [DW-1:0]   s_axis_a_tdata = '0;
    logic            s_axis_a_tlast = 1'b0;
    logic            s_axis_b_tvalid = 1'b0;
    logic            s_axis_b_tready;
    logic [DW-1:0]   s_axis_b_tdata = '0;
    logic            m_axis_tvalid;
    logic            m_axis_tready = 1'b0;
    logic [DW-1:0]   m_axis_tdata;
    logic [NB-1:0]   m_axis_tkeep;
    logic            m_axis_tlast;
    logic            stat_err_tlast;

    always #5 aclk = ~aclk;

    kvadd2_vadd2_core #(
        .C_DATA_WIDTH      (DW),
        .C_ELEM_WIDTH      (EW),
        .C_XFER_SIZE_WIDTH (XSW)
    ) dut (
        .aclk                    (aclk),
        .areset_n                (areset_n),
        .ap_start                (ap_start),
        .ap_done                 (ap_done),
        .ap_idle                 (ap_idle),
        .ctrl_xfer_size_in_bytes (ctrl_xfer_size_in_bytes),
        .ctrl_mode               (ctrl_mode),
        .ctrl_constant           (ctrl_constant),
        .s_axis_a_tvalid         (s_axis_a_tvalid),
        .s_axis_a_tready         (s_axis_a_tready),
        .s_axis_a_tdata          (s_axis_a_tdata),
        .s_axis_a_tlast          (s_axis_a_tlast),
        .s_axis_b_tvalid         (s_axis_b_tvalid),
        .s_axis_b_tready         (s_axis_b_tready),
        .s_axis_b_tdata          (s_axis_b_tdata),
        .m_axis_tvalid           (m_axis_tvalid),
        .m_axis_tready           (m_axis_tready),
        .m_axis_tdata            (m_axis_tdata),
        .m_axis_tkeep            (m_axis_tkeep),
        .m_axis_tlast            (m_axis_tlast),
        .stat_err_tlast          (stat_err_tlast)
    );

    int checks = 0;
    int passed = 0;

    // Input beats offered to the DUT and the tlast flag sent with each A beat.
    logic [DW-1:0] a_q[$];
    logic [DW-1:0] b_q[$];
    logic          a_last_q[$];
    // Beats accepted on C, and the beats the model expects.
    logic [DW-1:0] c_dat_q[$];
    logic [NB-1:0] c_keep_q[$];
    logic          c_last_q[$];
    logic [DW-1:0] e_dat_q[$];
    logic [NB-1:0] e_keep_q[$];
    logic          e_last_q[$];

    int r_a_acc, r_b_acc, r_done_cnt, r_done_cyc, r_last_cyc, r_first_cyc;
    bit r_timeout, r_join_bad, r_b_rdy_seen, r_stall_bad;

    // Reference arithmetic for one element.
    function automatic logic [31:0] model_lane(input logic [1:0] mode, input logic [31:0] a,
                                               input logic [31:0] b);
`ifdef KVADD2_SATURATE_EN
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = (mode == 2'd1) ? sa - sb : sa + sb;
        if (r > 64'sd2147483647)  r = 64'sd2147483647;
        if (r < -64'sd2147483648) r = -64'sd2147483648;
        return r[31:0];
`else
        longint r;
        r = (mode == 2'd1) ? longint'(a) - longint'(b) : longint'(a) + longint'(b);
        return r[31:0];
`endif
    endfunction

    // Expected C beats for the offered A/B queues.
    task automatic build_expected(input logic [1:0] mode, input logic [31:0] cst, input int bytes);
        int beats, res;
        logic [DW-1:0] av, bv, cv;
        logic [NB-1:0] kv;
        e_dat_q.delete(); e_keep_q.delete(); e_last_q.delete();
        beats = (bytes + NB - 1) / NB;
        res   = bytes % NB;
        for (int j = 0; j < beats; j++) begin
            av = a_q[j];
            bv = b_q[j];
            cv = '0;
            for (int i = 0; i < LANES; i++)
                cv[i*32 +: 32] = model_lane(mode, av[i*32 +: 32], (mode == 2'd2) ? cst : bv[i*32 +: 32]);
            kv = '1;
            if (j == beats - 1 && res != 0) kv = (64'd1 << res) - 64'd1;
            e_dat_q.push_back(cv);
            e_keep_q.push_back(kv);
            e_last_q.push_back(j == beats - 1);
        end
    endtask

    task automatic make_random_inputs(input int beats, input int total, input int tlast_beat);
        logic [DW-1:0] av, bv;
        a_q.delete(); b_q.delete(); a_last_q.delete();
        for (int j = 0; j < total; j++) begin
            for (int i = 0; i < LANES; i++) begin
                av[i*32 +: 32] = $urandom;
                bv[i*32 +: 32] = $urandom;
            end
            a_q.push_back(av);
            b_q.push_back(bv);
            a_last_q.push_back((tlast_beat < 0) ? (j == beats - 1) : (j == tlast_beat));
        end
    endtask

    // Start one transfer and drive A/B/C with the given valid/ready percentages until ap_done settles.
    task automatic run_xfer(input logic [1:0] mode, input logic [31:0] cst, input int bytes,
                            input int pv_a, input int pv_b, input int pr);
        int  a_idx = 0, b_idx = 0;
        bit  avld = 0, bvld = 0, a_fire = 0, b_fire = 0, fin = 0, stall = 0;
        logic [DW+NB:0] held = '0;
        c_dat_q.delete(); c_keep_q.delete(); c_last_q.delete();
        r_done_cnt = 0; r_done_cyc = -1; r_last_cyc = -1; r_first_cyc = -1;
        r_timeout = 0; r_join_bad = 0; r_b_rdy_seen = 0; r_stall_bad = 0;
        ctrl_xfer_size_in_bytes = bytes;
        ctrl_mode = mode;
        ctrl_constant = cst;
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            @(negedge aclk);
            ap_start = (cyc == 0);
            if (a_fire) begin a_idx++; avld = 0; end
            if (b_fire) begin b_idx++; bvld = 0; end
            if (!avld && a_idx < a_q.size() && int'($urandom % 100) < pv_a) avld = 1;
            if (!bvld && b_idx < b_q.size() && int'($urandom % 100) < pv_b) bvld = 1;
            s_axis_a_tvalid = avld;
            s_axis_a_tdata  = avld ? a_q[a_idx] : '0;
            s_axis_a_tlast  = avld ? a_last_q[a_idx] : 1'b0;
            s_axis_b_tvalid = bvld;
            s_axis_b_tdata  = bvld ? b_q[b_idx] : '0;
            m_axis_tready   = int'($urandom % 100) < pr;
            #1;
            a_fire = avld && s_axis_a_tready;
            b_fire = bvld && s_axis_b_tready;
            if (mode != 2'd2 && a_fire != b_fire) r_join_bad = 1;
            if (mode == 2'd2 && s_axis_b_tready) r_b_rdy_seen = 1;
            if (stall && (!m_axis_tvalid || {m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== held))
                r_stall_bad = 1;
            stall = m_axis_tvalid && !m_axis_tready;
            held  = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
            if (m_axis_tvalid && m_axis_tready) begin
                c_dat_q.push_back(m_axis_tdata);
                c_keep_q.push_back(m_axis_tkeep);
                c_last_q.push_back(m_axis_tlast);
                if (r_first_cyc < 0) r_first_cyc = cyc;
                if (m_axis_tlast) r_last_cyc = cyc;
            end
            if (ap_done) begin
                r_done_cnt++;
                if (r_done_cyc < 0) r_done_cyc = cyc;
            end
            if (r_done_cyc >= 0 && cyc >= r_done_cyc + 3) fin = 1;
        end
        r_timeout = !fin;
        r_a_acc = a_idx + (a_fire ? 1 : 0);
        r_b_acc = b_idx + (b_fire ? 1 : 0);
        @(negedge aclk);
        ap_start = 0; s_axis_a_tvalid = 0; s_axis_b_tvalid = 0; m_axis_tready = 0;
    endtask

    task automatic test_reset();
        ap_start = 0; s_axis_a_tvalid = 0; s_axis_b_tvalid = 0; m_axis_tready = 0;
        repeat (2) @(negedge aclk);
        areset_n = 0;
        #1;
        checks++; if (s_axis_a_tready !== 1'b0) $display("FAIL reset_a_tready: got %b want 0", s_axis_a_tready); else passed++;
        checks++; if (s_axis_b_tready !== 1'b0) $display("FAIL reset_b_tready: got %b want 0", s_axis_b_tready); else passed++;
        checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL reset_m_tvalid: got %b want 0", m_axis_tvalid); else passed++;
        checks++; if (ap_done !== 1'b0) $display("FAIL reset_ap_done: got %b want 0", ap_done); else passed++;
        checks++; if (ap_idle !== 1'b1) $display("FAIL reset_ap_idle: got %b want 1", ap_idle); else passed++;
        checks++; if (stat_err_tlast !== 1'b0) $display("FAIL reset_err: got %b want 0", stat_err_tlast); else passed++;
        repeat (2) @(negedge aclk);
        areset_n = 1;
        @(negedge aclk); #1;
        checks++; if (ap_idle !== 1'b1) $display("FAIL post_reset_idle: got %b want 1", ap_idle); else passed++;
    endtask

    task automatic test_add_ramp();
        logic [DW-1:0] av, bv, cv;
        a_q.delete(); b_q.delete(); a_last_q.delete();
        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < LANES; i++) begin
                av[i*32 +: 32] = 32'(j * LANES + i);
                bv[i*32 +: 32] = 32'(2 * (j * LANES + i));
            end
            a_q.push_back(av); b_q.push_back(bv); a_last_q.push_back(j == 3);
        end
        build_expected(2'd0, 32'd0, 256);
        run_xfer(2'd0, 32'd0, 256, 100, 100, 100);
        checks++; if (r_timeout) $display("FAIL add_timeout: got no ap_done want ap_done"); else passed++;
        checks++; if (c_dat_q.size() != 4) $display("FAIL add_count: got %0d want 4", c_dat_q.size()); else passed++;
        for (int j = 0; j < e_dat_q.size(); j++) begin
            cv = (j < c_dat_q.size()) ? c_dat_q[j] : '0;
            checks++;
            if (j >= c_dat_q.size() || cv !== e_dat_q[j] || c_keep_q[j] !== e_keep_q[j] || c_last_q[j] !== e_last_q[j])
                $display("FAIL add_beat%0d: got %h want %h", j, cv, e_dat_q[j]);
            else passed++;
        end
        // Element 37 lives in beat 2, lane 5: 37 + 74 = 111.
        cv = (c_dat_q.size() > 2) ? c_dat_q[2] : '0;
        checks++; if (cv[5*32 +: 32] !== 32'd111) $display("FAIL add_elem37: got %0d want 111", cv[5*32 +: 32]); else passed++;
        checks++; if (c_keep_q.size() < 4 || c_keep_q[3] !== {NB{1'b1}} || c_last_q[3] !== 1'b1)
            $display("FAIL add_final_keep_last: got beats %0d want full keep and tlast on beat 4", c_keep_q.size()); else passed++;
        checks++; if (r_done_cnt != 1 || r_done_cyc != r_last_cyc + 1)
            $display("FAIL add_done_timing: got cnt %0d cyc %0d want cnt 1 cyc %0d", r_done_cnt, r_done_cyc, r_last_cyc + 1); else passed++;
        checks++; if (r_last_cyc - r_first_cyc != 3)
            $display("FAIL add_throughput: got span %0d want 3", r_last_cyc - r_first_cyc); else passed++;
        checks++; if (stat_err_tlast !== 1'b0) $display("FAIL add_err: got %b want 0", stat_err_tlast); else passed++;
    endtask

    task automatic test_addc();
        logic [DW-1:0] cv;
        make_random_inputs(2, 2, -1);
        build_expected(2'd2, 32'd5, 100);
        run_xfer(2'd2, 32'd5, 100, 80, 80, 80);
        checks++; if (r_timeout || c_dat_q.size() != 2) $display("FAIL addc_count: got %0d want 2", c_dat_q.size()); else passed++;
        for (int j = 0; j < e_dat_q.size(); j++) begin
            cv = (j < c_dat_q.size()) ? c_dat_q[j] : '0;
            checks++;
            if (j >= c_dat_q.size() || cv !== e_dat_q[j] || c_keep_q[j] !== e_keep_q[j] || c_last_q[j] !== e_last_q[j])
                $display("FAIL addc_beat%0d: got %h want %h", j, cv, e_dat_q[j]);
            else passed++;
        end
        // 100 B = one full 64 B beat plus 36 residual bytes.
        checks++; if (c_keep_q.size() < 2 || c_keep_q[1] !== 64'h0000_000F_FFFF_FFFF)
            $display("FAIL addc_keep: got %h want 0000000fffffffff", (c_keep_q.size() > 1) ? c_keep_q[1] : '0); else passed++;
        checks++; if (r_b_rdy_seen || r_b_acc != 0) $display("FAIL addc_b_tready: got seen=%0d acc=%0d want 0", r_b_rdy_seen, r_b_acc); else passed++;
        checks++; if (r_done_cnt != 1) $display("FAIL addc_done: got %0d want 1", r_done_cnt); else passed++;
    endtask

    task automatic test_sub_and_overflow();
        logic [DW-1:0] av, bv, cv;
        a_q.delete(); b_q.delete(); a_last_q.delete();
        a_q.push_back('0); b_q.push_back({LANES{32'h0000_0001}}); a_last_q.push_back(1'b1);
        run_xfer(2'd1, 32'd0, 64, 100, 100, 100);
        cv = (c_dat_q.size() > 0) ? c_dat_q[0] : '0;
        checks++; if (c_dat_q.size() != 1 || cv !== {LANES{32'hFFFF_FFFF}})
            $display("FAIL sub_wrap: got %h want all ffffffff", cv); else passed++;

        av = {LANES{32'h7FFF_FFFF}};
        bv = {LANES{32'h0000_0001}};
        a_q.delete(); b_q.delete(); a_last_q.delete();
        a_q.push_back(av); b_q.push_back(bv); a_last_q.push_back(1'b1);
        run_xfer(2'd0, 32'd0, 64, 100, 100, 100);
        cv = (c_dat_q.size() > 0) ? c_dat_q[0] : '0;
`ifdef KVADD2_SATURATE_EN
        checks++; if (cv[31:0] !== 32'h7FFF_FFFF) $display("FAIL add_overflow: got %h want 7fffffff", cv[31:0]); else passed++;
`else
        checks++; if (cv[31:0] !== 32'h8000_0000) $display("FAIL add_overflow: got %h want 80000000", cv[31:0]); else passed++;
`endif
    endtask

    task automatic test_zero_len();
        make_random_inputs(0, 2, -1);
        run_xfer(2'd0, 32'd0, 0, 100, 100, 100);
        checks++; if (r_timeout || r_done_cnt != 1) $display("FAIL zero_done: got %0d want 1", r_done_cnt); else passed++;
        checks++; if (c_dat_q.size() != 0 || r_a_acc != 0)
            $display("FAIL zero_beats: got c=%0d a=%0d want 0 0", c_dat_q.size(), r_a_acc); else passed++;
    endtask

    task automatic test_tlast_err();
        logic [DW-1:0] cv;
        make_random_inputs(4, 4, 1);
        build_expected(2'd1, 32'd0, 256);
        run_xfer(2'd1, 32'd0, 256, 70, 70, 70);
        checks++; if (stat_err_tlast !== 1'b1) $display("FAIL tlast_err_flag: got %b want 1", stat_err_tlast); else passed++;
        checks++; if (r_timeout || c_dat_q.size() != 4) $display("FAIL tlast_err_count: got %0d want 4", c_dat_q.size()); else passed++;
        for (int j = 0; j < e_dat_q.size(); j++) begin
            cv = (j < c_dat_q.size()) ? c_dat_q[j] : '0;
            checks++;
            if (j >= c_dat_q.size() || cv !== e_dat_q[j] || c_keep_q[j] !== e_keep_q[j] || c_last_q[j] !== e_last_q[j])
                $display("FAIL tlast_err_beat%0d: got %h want %h", j, cv, e_dat_q[j]);
            else passed++;
        end
    endtask

    task automatic test_random_stress();
        logic [DW-1:0] cv;
        logic [1:0]    mode;
        logic [31:0]   cst;
        int bytes, beats;
        for (int it = 0; it < 8; it++) begin
            mode  = 2'($urandom % 4);
            cst   = $urandom;
            bytes = (it % 3 == 0) ? 64 * int'($urandom_range(1, 6)) : int'($urandom_range(1, 700));
            beats = (bytes + NB - 1) / NB;
            make_random_inputs(beats, beats + 1, -1);
            build_expected(mode, cst, bytes);
            run_xfer(mode, cst, bytes, int'($urandom_range(40, 100)), int'($urandom_range(40, 100)),
                     int'($urandom_range(30, 100)));
            checks++; if (r_timeout || c_dat_q.size() != beats)
                $display("FAIL rnd%0d_count: got %0d want %0d", it, c_dat_q.size(), beats); else passed++;
            for (int j = 0; j < e_dat_q.size(); j++) begin
                cv = (j < c_dat_q.size()) ? c_dat_q[j] : '0;
                checks++;
                if (j >= c_dat_q.size() || cv !== e_dat_q[j] || c_keep_q[j] !== e_keep_q[j] || c_last_q[j] !== e_last_q[j])
                    $display("FAIL rnd%0d_beat%0d: got %h want %h", it, j, cv, e_dat_q[j]);
                else passed++;
            end
            checks++; if (r_a_acc != beats || (mode != 2'd2 && r_b_acc != beats))
                $display("FAIL rnd%0d_consumed: got a=%0d b=%0d want %0d", it, r_a_acc, r_b_acc, beats); else passed++;
            checks++; if (r_join_bad || r_stall_bad)
                $display("FAIL rnd%0d_protocol: got join_bad=%0d stall_bad=%0d want 0 0", it, r_join_bad, r_stall_bad); else passed++;
            checks++; if (r_done_cnt != 1 || r_done_cyc != r_last_cyc + 1 || stat_err_tlast !== 1'b0)
                $display("FAIL rnd%0d_done: got cnt=%0d cyc=%0d err=%b want 1 %0d 0", it, r_done_cnt, r_done_cyc, stat_err_tlast, r_last_cyc + 1); else passed++;
        end
    endtask

    task automatic test_reset_midrun();
        bit done_seen = 0, vld_seen = 0;
        make_random_inputs(8, 8, -1);
        ctrl_xfer_size_in_bytes = 512; ctrl_mode = 2'd0; ctrl_constant = '0;
        @(negedge aclk);
        ap_start = 1;
        s_axis_a_tvalid = 1; s_axis_a_tdata = a_q[0]; s_axis_a_tlast = 0;
        s_axis_b_tvalid = 1; s_axis_b_tdata = b_q[0];
        m_axis_tready = 0;
        @(negedge aclk);
        ap_start = 0;
        repeat (4) @(negedge aclk);
        #1;
        checks++; if (m_axis_tvalid !== 1'b1 || ap_idle !== 1'b0)
            $display("FAIL midrun_active: got tvalid=%b idle=%b want 1 0", m_axis_tvalid, ap_idle); else passed++;
        areset_n = 0;
        #1;
        checks++; if (m_axis_tvalid !== 1'b0 || s_axis_a_tready !== 1'b0 || s_axis_b_tready !== 1'b0)
            $display("FAIL midrun_reset_hs: got %b%b%b want 000", m_axis_tvalid, s_axis_a_tready, s_axis_b_tready); else passed++;
        checks++; if (ap_idle !== 1'b1 || ap_done !== 1'b0)
            $display("FAIL midrun_reset_ctl: got idle=%b done=%b want 1 0", ap_idle, ap_done); else passed++;
        s_axis_a_tvalid = 0; s_axis_b_tvalid = 0; m_axis_tready = 1;
        repeat (2) @(negedge aclk);
        areset_n = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge aclk); #1;
            if (ap_done) done_seen = 1;
            if (m_axis_tvalid) vld_seen = 1;
        end
        checks++; if (done_seen || vld_seen)
            $display("FAIL midrun_after: got done=%0d tvalid=%0d want 0 0", done_seen, vld_seen); else passed++;
        make_random_inputs(2, 2, -1);
        run_xfer(2'd0, 32'd0, 128, 100, 100, 100);
        checks++; if (r_timeout || c_dat_q.size() != 2 || r_done_cnt != 1)
            $display("FAIL midrun_recover: got beats=%0d done=%0d want 2 1", c_dat_q.size(), r_done_cnt); else passed++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_add_ramp();
        test_addc();
        test_sub_and_overflow();
        test_zero_len();
        test_tlast_err();
        test_random_stress();
        test_reset_midrun();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
